// File: rtl/rvfi_trace_fifo_if.sv
// Retirement-record input bus and valid/ready output port of the RVFI trace FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface rvfi_trace_fifo_if;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_order;
  logic [31:0] out_insn;
  logic [31:0] out_pc_rdata;
  logic [31:0] out_pc_wdata;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic [31:0] out_mem_addr;
  logic [3:0]  out_mem_rmask;
  logic [3:0]  out_mem_wmask;
  logic [31:0] out_mem_rdata;
  logic [31:0] out_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
    input  out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask,
           out_mem_wmask, out_mem_rdata, out_mem_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
    output out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask,
           out_mem_wmask, out_mem_rdata, out_mem_wdata
  );
endinterface

// File: rtl/rvfi_trace_fifo.sv
// Captures RVFI retirement records into a FIFO drained over valid/ready,
// counting dropped records and flagging PC-continuity breaks.
module rvfi_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_trace_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   pc_error,
  output logic [63:0]            pc_error_order
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             in_rec, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             prev_valid;
  logic [31:0]      last_pc_wdata;
  logic             full, push, pop, drop, pc_break;

  always_comb begin
    in_rec           = '0;
    in_rec.order     = bus.rvfi_order;
    in_rec.insn      = bus.rvfi_insn;
    in_rec.pc_rdata  = bus.rvfi_pc_rdata;
    in_rec.pc_wdata  = bus.rvfi_pc_wdata;
    in_rec.rd_addr   = bus.rvfi_rd_addr;
    in_rec.rd_wdata  = bus.rvfi_rd_wdata;
    in_rec.mem_addr  = bus.rvfi_mem_addr;
    in_rec.mem_rmask = bus.rvfi_mem_rmask;
    in_rec.mem_wmask = bus.rvfi_mem_wmask;
    in_rec.mem_rdata = bus.rvfi_mem_rdata;
    in_rec.mem_wdata = bus.rvfi_mem_wdata;
  end

  assign full     = (cnt == FULL_LVL);
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = bus.rvfi_valid && (!full || pop);
  assign drop     = bus.rvfi_valid && full && !pop;
  assign pc_break = bus.rvfi_valid && prev_valid && (bus.rvfi_pc_rdata != last_pc_wdata);

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      overflow       <= 1'b0;
      drop_count     <= '0;
      pc_error       <= 1'b0;
      pc_error_order <= '0;
      prev_valid     <= 1'b0;
      last_pc_wdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
      // Dropped records still advance the continuity chain.
      if (bus.rvfi_valid) begin
        prev_valid    <= 1'b1;
        last_pc_wdata <= bus.rvfi_pc_wdata;
        if (pc_break) begin
          pc_error <= 1'b1;
          if (!pc_error) pc_error_order <= bus.rvfi_order;
        end
      end
    end
  end

  assign level         = cnt;
  assign bus.out_valid = (cnt != '0);
  assign head          = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.out_order     = head.order;
  assign bus.out_insn      = head.insn;
  assign bus.out_pc_rdata  = head.pc_rdata;
  assign bus.out_pc_wdata  = head.pc_wdata;
  assign bus.out_rd_addr   = head.rd_addr;
  assign bus.out_rd_wdata  = head.rd_wdata;
  assign bus.out_mem_addr  = head.mem_addr;
  assign bus.out_mem_rmask = head.mem_rmask;
  assign bus.out_mem_wmask = head.mem_wmask;
  assign bus.out_mem_rdata = head.mem_rdata;
  assign bus.out_mem_wdata = head.mem_wdata;
endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Scoreboard bench for rvfi_trace_fifo: directed retirement sequences,
// a negedge monitor pops expected records whenever the consumer accepts one.
module tb_rvfi_trace_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  rvfi_trace_fifo_if bus ();
  rvfi_trace_fifo_if bus2 ();

  logic [3:0]  level;
  logic        overflow, pc_error;
  logic [15:0] drop_count;
  logic [63:0] pc_error_order;

  logic [2:0]  level2;
  logic        overflow2, pc_error2;
  logic [1:0]  drop_count2;
  logic [63:0] pc_error_order2;

  rvfi_trace_fifo #(.DEPTH(8), .CNT_W(16)) dut (
    .clock(clk), .reset(reset), .bus(bus.slave), .level(level), .overflow(overflow),
    .drop_count(drop_count), .pc_error(pc_error), .pc_error_order(pc_error_order)
  );

  rvfi_trace_fifo #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clock(clk), .reset(reset), .bus(bus2.slave), .level(level2), .overflow(overflow2),
    .drop_count(drop_count2), .pc_error(pc_error2), .pc_error_order(pc_error_order2)
  );

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] npc);
    rec_t r;
    logic [31:0] o32;
    o32         = o[31:0];
    r.order     = o;
    r.insn      = {o32[15:0], 16'h0013};
    r.pc_rdata  = pc;
    r.pc_wdata  = npc;
    r.rd_addr   = o32[4:0];
    r.rd_wdata  = (o32[4:0] == 5'd0) ? 32'd0 : (o32 ^ 32'hA5A5_0000);
    r.mem_addr  = 32'h8000_0000 + (o32 << 2);
    r.mem_rmask = o32[0] ? 4'hF : 4'h0;
    r.mem_wmask = o32[0] ? 4'h0 : 4'h3;
    r.mem_rdata = o32 * 3;
    r.mem_wdata = ~o32;
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; presents one record for exactly one edge.
  task automatic ret(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] npc, input bit keep);
    rec_t r;
    r = mk(o, pc, npc);
    if (keep) exp_q.push_back(r);
    bus.rvfi_valid     = 1'b1;
    bus.rvfi_order     = r.order;
    bus.rvfi_insn      = r.insn;
    bus.rvfi_pc_rdata  = r.pc_rdata;
    bus.rvfi_pc_wdata  = r.pc_wdata;
    bus.rvfi_rd_addr   = r.rd_addr;
    bus.rvfi_rd_wdata  = r.rd_wdata;
    bus.rvfi_mem_addr  = r.mem_addr;
    bus.rvfi_mem_rmask = r.mem_rmask;
    bus.rvfi_mem_wmask = r.mem_wmask;
    bus.rvfi_mem_rdata = r.mem_rdata;
    bus.rvfi_mem_wdata = r.mem_wdata;
    sync();
    bus.rvfi_valid = 1'b0;
  endtask

  task automatic drive2(input logic [63:0] o, input logic [31:0] pc);
    rec_t r;
    r = mk(o, pc, pc + 32'd4);
    bus2.rvfi_valid     = 1'b1;
    bus2.rvfi_order     = r.order;
    bus2.rvfi_insn      = r.insn;
    bus2.rvfi_pc_rdata  = r.pc_rdata;
    bus2.rvfi_pc_wdata  = r.pc_wdata;
    bus2.rvfi_rd_addr   = r.rd_addr;
    bus2.rvfi_rd_wdata  = r.rd_wdata;
    bus2.rvfi_mem_addr  = r.mem_addr;
    bus2.rvfi_mem_rmask = r.mem_rmask;
    bus2.rvfi_mem_wmask = r.mem_wmask;
    bus2.rvfi_mem_rdata = r.mem_rdata;
    bus2.rvfi_mem_wdata = r.mem_wdata;
    sync();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    chk("drain_done", {63'd0, done}, 64'd1);
    sync();
  endtask

  // Scoreboard monitor: the head shown at a negedge with ready high is consumed at the next edge.
  always @(negedge clk) begin
    rec_t got, exp;
    if (reset && bus.out_valid && bus.out_ready) begin
      got = '{order: bus.out_order, insn: bus.out_insn, pc_rdata: bus.out_pc_rdata,
              pc_wdata: bus.out_pc_wdata, rd_addr: bus.out_rd_addr, rd_wdata: bus.out_rd_wdata,
              mem_addr: bus.out_mem_addr, mem_rmask: bus.out_mem_rmask, mem_wmask: bus.out_mem_wmask,
              mem_rdata: bus.out_mem_rdata, mem_wdata: bus.out_mem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected actual_order=%0d expected=none", got.order);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL scoreboard_record actual=%h expected=%h", got, exp);
        end
      end
    end
  end

  logic [31:0] pc;

  initial begin
    bus.rvfi_valid = 1'b0; bus.rvfi_order = '0; bus.rvfi_insn = '0; bus.rvfi_pc_rdata = '0;
    bus.rvfi_pc_wdata = '0; bus.rvfi_rd_addr = '0; bus.rvfi_rd_wdata = '0; bus.rvfi_mem_addr = '0;
    bus.rvfi_mem_rmask = '0; bus.rvfi_mem_wmask = '0; bus.rvfi_mem_rdata = '0; bus.rvfi_mem_wdata = '0;
    bus.out_ready = 1'b0;
    bus2.rvfi_valid = 1'b0; bus2.rvfi_order = '0; bus2.rvfi_insn = '0; bus2.rvfi_pc_rdata = '0;
    bus2.rvfi_pc_wdata = '0; bus2.rvfi_rd_addr = '0; bus2.rvfi_rd_wdata = '0; bus2.rvfi_mem_addr = '0;
    bus2.rvfi_mem_rmask = '0; bus2.rvfi_mem_wmask = '0; bus2.rvfi_mem_rdata = '0; bus2.rvfi_mem_wdata = '0;
    bus2.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_pc_error", 64'(pc_error), 64'd0);
    chk("rst_pc_error_order", pc_error_order, 64'd0);
    sync();
    reset = 1'b1;

    // Three retirements with a ready consumer
    bus.out_ready = 1'b1;
    ret(64'd1, 32'h0, 32'h4, 1'b1);
    @(negedge clk);
    chk("t1_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_latency_order", bus.out_order, 64'd1);
    chk("t1_level_1", 64'(level), 64'd1);
    sync();
    ret(64'd2, 32'h4, 32'h8, 1'b1);
    @(negedge clk);
    chk("t1_level_2", 64'(level), 64'd1);
    sync();
    ret(64'd3, 32'h8, 32'hC, 1'b1);
    @(negedge clk);
    chk("t1_level_3", 64'(level), 64'd1);
    sync();
    drain();
    chk("t1_pc_error", 64'(pc_error), 64'd0);

    // Ten retirements into a stalled consumer: two drops
    bus.out_ready = 1'b0;
    pc = 32'hC;
    for (int i = 0; i < 10; i++) begin
      ret(64'(10 + i), pc, pc + 32'd4, i < 8);
      pc = pc + 32'd4;
    end
    @(negedge clk);
    chk("t2_level_full", 64'(level), 64'd8);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_drop_count", 64'(drop_count), 64'd2);
    chk("t2_head_held", bus.out_order, 64'd10);
    chk("t2_pc_error", 64'(pc_error), 64'd0);
    sync();

    // Push and pop in the same cycle while full
    bus.out_ready = 1'b1;
    ret(64'd20, pc, pc + 32'd4, 1'b1);
    pc = pc + 32'd4;
    @(negedge clk);
    chk("t3_level_still_full", 64'(level), 64'd8);
    chk("t3_no_new_drop", 64'(drop_count), 64'd2);
    sync();
    drain();

    // PC continuity break, first violation latched
    ret(64'd5, pc, 32'h100, 1'b1);
    @(negedge clk);
    chk("t4_no_error_yet", 64'(pc_error), 64'd0);
    sync();
    ret(64'd6, 32'h200, 32'h204, 1'b1);
    @(negedge clk);
    chk("t4_pc_error", 64'(pc_error), 64'd1);
    chk("t4_pc_error_order", pc_error_order, 64'd6);
    sync();
    ret(64'd7, 32'h204, 32'h208, 1'b1);
    ret(64'd8, 32'h208, 32'h20C, 1'b1);
    ret(64'd9, 32'h300, 32'h304, 1'b1);
    @(negedge clk);
    chk("t4_order_kept", pc_error_order, 64'd6);
    chk("t4_pc_error_sticky", 64'(pc_error), 64'd1);
    sync();
    drain();

    // Mid-operation reset with four stored entries
    bus.out_ready = 1'b0;
    pc = 32'h304;
    for (int i = 0; i < 4; i++) begin
      ret(64'(30 + i), pc, pc + 32'd4, 1'b1);
      pc = pc + 32'd4;
    end
    @(negedge clk);
    chk("t5_level_4", 64'(level), 64'd4);
    sync();
    reset = 1'b0;
    sync();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_level", 64'(level), 64'd0);
    chk("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_out_order", bus.out_order, 64'd0);
    chk("t5_rst_overflow", 64'(overflow), 64'd0);
    chk("t5_rst_drop_count", 64'(drop_count), 64'd0);
    chk("t5_rst_pc_error", 64'(pc_error), 64'd0);
    chk("t5_rst_pc_error_order", pc_error_order, 64'd0);
    sync();
    bus.out_ready = 1'b1;
    ret(64'd40, 32'h5000, 32'h5004, 1'b1);
    @(negedge clk);
    chk("t5_first_unchecked", 64'(pc_error), 64'd0);
    sync();
    drain();

    // Saturating 2-bit drop counter on a depth-4 instance
    pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      drive2(64'(50 + i), pc);
      pc = pc + 32'd4;
    end
    bus2.rvfi_valid = 1'b0;
    @(negedge clk);
    chk("t6_level2_full", 64'(level2), 64'd4);
    chk("t6_drop2_count2", 64'(drop_count2), 64'd2);
    sync();
    for (int i = 6; i < 9; i++) begin
      drive2(64'(50 + i), pc);
      pc = pc + 32'd4;
    end
    bus2.rvfi_valid = 1'b0;
    @(negedge clk);
    chk("t6_drop2_saturated", 64'(drop_count2), 64'd3);
    chk("t6_overflow2", 64'(overflow2), 64'd1);
    chk("t6_pc_error2", 64'(pc_error2), 64'd0);
    chk("t6_head2_order", bus2.out_order, 64'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
- Sits directly downstream of the core's RVFI retirement monitor.
- Captures every retired-instruction record (rvfi_valid high) into a FIFO and drains it over a valid/ready port to the trace consumer (contract/leakage checker or testbench sink).
- Flags dropped records and PC-continuity breaks between consecutive retirements, so a lossy or inconsistent trace is never silently consumed.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, >= 2
CNT_W, 16, width of the saturating drop counter

Ports:
clock  input  1  core clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
rvfi_valid  input  1  retirement record present this cycle
rvfi_order  input  64  retirement index
rvfi_insn  input  32  instruction word
rvfi_pc_rdata  input  32  PC of retired instruction
rvfi_pc_wdata  input  32  next PC
rvfi_rd_addr  input  5  destination register
rvfi_rd_wdata  input  32  destination write value (0 when rd=0)
rvfi_mem_addr  input  32  memory address
rvfi_mem_rmask  input  4  read byte mask
rvfi_mem_wmask  input  4  write byte mask
rvfi_mem_rdata  input  32  masked read data
rvfi_mem_wdata  input  32  masked write data
out_valid  output  1  head record available
out_ready  input  1  consumer accepts head record
out_order, out_insn, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata  output  same widths as inputs  head record fields
level  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: at least one record dropped
drop_count  output  CNT_W  dropped records, saturating at all-ones
pc_error  output  1  sticky: PC continuity violation seen
pc_error_order  output  64  rvfi_order of first violating record

Behaviour:
- Reset (reset==0 at a clock edge): level=0, out_valid=0, all out_* fields=0, overflow=0, drop_count=0, pc_error=0, pc_error_order=0, prev_valid=0. Reset mid-operation discards all stored entries and restarts the continuity chain.
- Push condition: rvfi_valid && (level<DEPTH || pop). All 11 fields are written at the tail.
- Pop condition: out_valid && out_ready. The head advances.
- Simultaneous push and pop, including when full, is legal; level is unchanged.
- Latency: a record pushed at edge N is visible on out_* with out_valid=1 from cycle N+1 when the FIFO was empty. No combinational path from rvfi_* to out_*.
- out_* hold stable while out_valid && !out_ready. out_* are don't-care when out_valid=0; the bench checks them only when valid.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level = pushes - pops and never exceeds DEPTH or goes below 0.
- Drop condition: rvfi_valid && level==DEPTH && !pop.
  - The record is discarded, overflow is set, and drop_count increments unless it is already all-ones.
- Continuity check runs on every rvfi_valid cycle, including dropped records.
  - If prev_valid && rvfi_pc_rdata != last_pc_wdata, then pc_error is set.
  - pc_error_order is captured only on the first violation, i.e. when pc_error was 0.
  - Then last_pc_wdata <= rvfi_pc_wdata and prev_valid <= 1.
  - The first retirement after reset is never checked.
- overflow and pc_error clear only on reset.
- rvfi_valid=0 cycles affect nothing except the pop logic.

Test Plan:
- Reset, then 3 retirements (order 1..3, pc 0x0→0x4→0x8, pc_wdata = pc+4) with out_ready=1 → out_valid one cycle after each, fields match in order, level peaks at 1, pc_error=0.
- out_ready=0, DEPTH=8, 10 consecutive retirements → level=8, overflow=1, drop_count=2, records 1..8 drained intact in order once out_ready=1.
- Full FIFO, rvfi_valid and out_ready both 1 in the same cycle → no drop, level stays 8, new record lands at the wrapped tail and appears after 7 further pops.
- Retirement order 5 with pc_wdata=0x100, then order 6 with pc_rdata=0x200 → pc_error=1, pc_error_order=6. A later break at order 9 leaves pc_error_order=6.
- Assert reset low with 4 entries stored → next cycle level=0, out_valid=0, sticky flags cleared. The first post-reset retirement with any pc_rdata produces no pc_error.
- CNT_W=2, 5 drops → drop_count saturates at 3, overflow=1.
